// File: rtl/control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : control_fsm
// Purpose  : Multi-cycle control unit for the basic processor. Moves each
//            instruction through FETCH, DECODE, EXEC, MEM and WB with a
//            memory handshake. Also provides HALT, an illegal-opcode trap and
//            a memory-timeout trap.
// Revision : 1.0 - initial multi-cycle release
// ============================================================================
module control_fsm #(
    parameter int OPW  = 4,
    parameter int ALUW = 2,
    parameter int TMO  = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [OPW-1:0]  opcd,
    input  logic            mem_ack,
    input  logic            clr_trap,
    output logic [ALUW-1:0] alucnt,
    output logic [1:0]      sel,
    output logic            we,
    output logic [1:0]      branch,
    output logic            ir_we,
    output logic            pc_inc,
    output logic            mem_req,
    output logic            mem_we,
    output logic            busy,
    output logic            halted,
    output logic            trap,
    output logic [1:0]      trap_cause
);

    // The timeout counter keeps at least one bit so that TMO=0 still elaborates.
    localparam int c_CW = (TMO > 0) ? $clog2(TMO + 1) : 1;
    localparam logic [c_CW-1:0] c_TLAST = (TMO > 0) ? c_CW'(TMO - 1) : '0;

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_FETCH  = 3'd1;
    localparam logic [2:0] c_DECODE = 3'd2;
    localparam logic [2:0] c_EXEC   = 3'd3;
    localparam logic [2:0] c_MEM    = 3'd4;
    localparam logic [2:0] c_WB     = 3'd5;
    localparam logic [2:0] c_TRAP   = 3'd6;
    localparam logic [2:0] c_HALT   = 3'd7;

    localparam logic [3:0] c_OP_NOP  = 4'h0;
    localparam logic [3:0] c_OP_ADD  = 4'h1;
    localparam logic [3:0] c_OP_SUB  = 4'h2;
    localparam logic [3:0] c_OP_AND  = 4'h3;
    localparam logic [3:0] c_OP_OR   = 4'h4;
    localparam logic [3:0] c_OP_LD   = 4'h5;
    localparam logic [3:0] c_OP_ST   = 4'h6;
    localparam logic [3:0] c_OP_LDI  = 4'h7;
    localparam logic [3:0] c_OP_BEQ  = 4'hC;
    localparam logic [3:0] c_OP_BLT  = 4'hD;
    localparam logic [3:0] c_OP_HALT = 4'hF;

    logic [2:0]      r_state;
    logic [2:0]      w_next;
    logic [3:0]      r_op;
    logic [c_CW-1:0] r_cnt;
    logic [1:0]      r_cause;
    logic            w_hi_zero;
    logic            w_legal;
    logic            w_tmo;
    logic            w_memwait;
    logic [1:0]      w_alu;

    // Opcode bits above the 4-bit field must be zero for a legal instruction.
    generate
        if (OPW > 4) begin : g_wide
            assign w_hi_zero = (opcd[OPW-1:4] == '0);
        end else begin : g_narrow
            assign w_hi_zero = 1'b1;
        end
    endgenerate

    // Legal-opcode check on the opcode being decoded.
    always_comb begin
        w_legal = 1'b0;
        case (opcd[3:0])
            c_OP_NOP, c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR, c_OP_LD,
            c_OP_ST, c_OP_LDI, c_OP_BEQ, c_OP_BLT, c_OP_HALT: w_legal = w_hi_zero;
            default: w_legal = 1'b0;
        endcase
    end

    assign w_memwait = (r_state == c_FETCH) || (r_state == c_MEM);
    assign w_tmo     = (TMO > 0) && (r_cnt == c_TLAST);

    // Next-state selection. An ack always takes priority over a timeout.
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:   if (start) w_next = c_FETCH;
            c_FETCH: begin
                if (mem_ack)    w_next = c_DECODE;
                else if (w_tmo) w_next = c_TRAP;
            end
            c_DECODE: begin
                if (!w_legal)                     w_next = c_TRAP;
                else if (opcd[3:0] == c_OP_HALT)  w_next = c_HALT;
                else if (opcd[3:0] == c_OP_NOP)   w_next = c_FETCH;
                else                              w_next = c_EXEC;
            end
            c_EXEC:   w_next = ((r_op == c_OP_LD) || (r_op == c_OP_ST)) ? c_MEM : c_FETCH;
            c_MEM: begin
                if (mem_ack)    w_next = (r_op == c_OP_ST) ? c_FETCH : c_WB;
                else if (w_tmo) w_next = c_TRAP;
            end
            c_WB:     w_next = c_FETCH;
            c_TRAP:   if (clr_trap) w_next = c_IDLE;
            c_HALT:   if (start) w_next = c_FETCH;
            default:  w_next = c_IDLE;
        endcase
    end

    // State, latched opcode, timeout counter and trap cause.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_op    <= 4'h0;
            r_cnt   <= '0;
            r_cause <= 2'b00;
        end else begin
            r_state <= w_next;
            if (r_state == c_DECODE) r_op <= opcd[3:0];
            // Count only while still waiting in FETCH/MEM; any move clears it.
            if ((TMO > 0) && w_memwait && (w_next == r_state))
                r_cnt <= r_cnt + c_CW'(1);
            else
                r_cnt <= '0;
            if (w_memwait && (w_next == c_TRAP))
                r_cause <= 2'b10;
            else if ((r_state == c_DECODE) && (w_next == c_TRAP))
                r_cause <= 2'b01;
            else if ((r_state == c_TRAP) && clr_trap)
                r_cause <= 2'b00;
        end
    end

    // Output decode from state and latched opcode; all outputs are forced low while rst is high.
    always_comb begin
        w_alu      = 2'd0;
        sel        = 2'd0;
        we         = 1'b0;
        branch     = 2'b00;
        ir_we      = 1'b0;
        pc_inc     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        busy       = 1'b0;
        halted     = 1'b0;
        trap       = 1'b0;
        trap_cause = 2'b00;
        if (!rst) begin
            case (r_state)
                c_FETCH: begin
                    busy    = 1'b1;
                    mem_req = 1'b1;
                    ir_we   = mem_ack;
                end
                c_DECODE: begin
                    busy   = 1'b1;
                    pc_inc = w_legal && (opcd[3:0] != c_OP_HALT);
                end
                c_EXEC: begin
                    busy = 1'b1;
                    case (r_op)
                        c_OP_ADD: begin w_alu = 2'd0; we = 1'b1; end
                        c_OP_SUB: begin w_alu = 2'd1; we = 1'b1; end
                        c_OP_AND: begin w_alu = 2'd2; we = 1'b1; end
                        c_OP_OR:  begin w_alu = 2'd3; we = 1'b1; end
                        c_OP_LDI: begin sel = 2'd1;   we = 1'b1; end
                        c_OP_BEQ: begin w_alu = 2'd1; branch = 2'b01; end
                        c_OP_BLT: begin w_alu = 2'd1; branch = 2'b10; end
                        default:  w_alu = 2'd0;
                    endcase
                end
                c_MEM: begin
                    busy    = 1'b1;
                    mem_req = 1'b1;
                    mem_we  = (r_op == c_OP_ST);
                end
                c_WB: begin
                    busy = 1'b1;
                    sel  = 2'd2;
                    we   = 1'b1;
                end
                c_TRAP: begin
                    trap       = 1'b1;
                    trap_cause = r_cause;
                end
                c_HALT:  halted = 1'b1;
                default: busy = 1'b0;
            endcase
        end
        alucnt = ALUW'(w_alu);
    end

endmodule
`default_nettype wire
